// File: rtl/ssd1331_spi_receiver_if.sv
// rtl/ssd1331_spi_receiver_if.sv - SPI link inputs and decoded byte/command/pixel outputs of the SSD1331 receiver
interface ssd1331_spi_receiver_if #(
    parameter int COL_W        = 3,
    parameter int ROW_W        = 3,
    parameter int N_COLOR_BITS = 8
);
    logic                    i_CS;
    logic                    i_SCK;
    logic                    i_MOSI;
    logic                    i_DC;
    logic [7:0]              o_BYTE;
    logic                    o_BYTE_DC;
    logic                    o_BYTE_VALID;
    logic [7:0]              o_CMD;
    logic                    o_CMD_VALID;
    logic                    o_PIX_WE;
    logic [COL_W-1:0]        o_PIX_COL;
    logic [ROW_W-1:0]        o_PIX_ROW;
    logic [N_COLOR_BITS-1:0] o_PIX_DATA;
    logic                    o_FRAME_DONE;

    // master drives the SPI link and observes the decoded results
    modport master (
        output i_CS, i_SCK, i_MOSI, i_DC,
        input  o_BYTE, o_BYTE_DC, o_BYTE_VALID, o_CMD, o_CMD_VALID,
        input  o_PIX_WE, o_PIX_COL, o_PIX_ROW, o_PIX_DATA, o_FRAME_DONE
    );

    modport slave (
        input  i_CS, i_SCK, i_MOSI, i_DC,
        output o_BYTE, o_BYTE_DC, o_BYTE_VALID, o_CMD, o_CMD_VALID,
        output o_PIX_WE, o_PIX_COL, o_PIX_ROW, o_PIX_DATA, o_FRAME_DONE
    );
endinterface

// File: rtl/ssd1331_spi_receiver.sv
// rtl/ssd1331_spi_receiver.sv - oversampling 4-wire SPI receiver with SSD1331 window decode and pixel writes
module ssd1331_spi_receiver #(
    parameter int NUM_COL      = 8,
    parameter int NUM_ROW      = 8,
    parameter int COL_W        = 3,
    parameter int ROW_W        = 3,
    parameter int N_COLOR_BITS = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    ssd1331_spi_receiver_if.slave link
);
    localparam logic [7:0] COL_MAX = 8'(NUM_COL - 1);
    localparam logic [7:0] ROW_MAX = 8'(NUM_ROW - 1);

    typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;

    logic [1:0] cs_sync, sck_sync, mosi_sync, dc_sync;
    logic       sck_d;
    logic       sck_rise;
    logic       rise_q, bit_q, dcbit_q;
    logic [2:0] bit_cnt;
    logic [6:0] shift_q;
    logic [7:0] byte_q;
    logic       byte_dc_q, byte_valid_q;

    state_t     state_q, state_d;
    logic [7:0] opcode_q, arg1_q, cmd_q, cmd_code_d;
    logic       cmd_valid_q;
    logic       opcode_ld, arg1_ld, win_apply, cmd_fire, pix_fire;

    logic [COL_W-1:0] col_start, col_end, col_ptr;
    logic [ROW_W-1:0] row_start, row_end, row_ptr;
    logic [COL_W-1:0] new_col_lo, new_col_hi_raw, new_col_hi;
    logic [ROW_W-1:0] new_row_lo, new_row_hi_raw, new_row_hi;

    logic                    pix_we_q, frame_done_q;
    logic [COL_W-1:0]        pix_col_q;
    logic [ROW_W-1:0]        pix_row_q;
    logic [N_COLOR_BITS-1:0] pix_data_q;

    function automatic logic [COL_W-1:0] clamp_col(input logic [7:0] v);
        if (v > COL_MAX) return COL_MAX[COL_W-1:0];
        return v[COL_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] clamp_row(input logic [7:0] v);
        if (v > ROW_MAX) return ROW_MAX[ROW_W-1:0];
        return v[ROW_W-1:0];
    endfunction

    function automatic logic takes_arg(input logic [7:0] op);
        case (op)
            8'h15, 8'h75,
            8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C,
            8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD,
            8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic is_window(input logic [7:0] op);
        return (op == 8'h15) || (op == 8'h75);
    endfunction

    // CS idles high so an unsynchronised reset release never looks like a selected link
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            cs_sync   <= 2'b11;
            sck_sync  <= 2'b00;
            mosi_sync <= 2'b00;
            dc_sync   <= 2'b00;
            sck_d     <= 1'b0;
            rise_q    <= 1'b0;
            bit_q     <= 1'b0;
            dcbit_q   <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], link.i_CS};
            sck_sync  <= {sck_sync[0], link.i_SCK};
            mosi_sync <= {mosi_sync[0], link.i_MOSI};
            dc_sync   <= {dc_sync[0], link.i_DC};
            sck_d     <= sck_sync[1];
            rise_q    <= sck_rise & ~cs_sync[1];
            bit_q     <= mosi_sync[1];
            dcbit_q   <= dc_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_d;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            bit_cnt      <= 3'd0;
            shift_q      <= 7'd0;
            byte_q       <= 8'd0;
            byte_dc_q    <= 1'b0;
            byte_valid_q <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            if (cs_sync[1]) begin
                bit_cnt <= 3'd0;
            end else if (rise_q) begin
                shift_q <= {shift_q[5:0], bit_q};
                if (bit_cnt == 3'd7) begin
                    byte_q       <= {shift_q, bit_q};
                    byte_dc_q    <= dcbit_q;
                    byte_valid_q <= 1'b1;
                    bit_cnt      <= 3'd0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // a data byte always wins: any half-received command is dropped and the byte becomes a pixel
    always_comb begin
        state_d    = state_q;
        opcode_ld  = 1'b0;
        arg1_ld    = 1'b0;
        win_apply  = 1'b0;
        cmd_fire   = 1'b0;
        pix_fire   = 1'b0;
        cmd_code_d = opcode_q;
        if (byte_valid_q) begin
            if (byte_dc_q) begin
                state_d  = IDLE;
                pix_fire = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        opcode_ld  = 1'b1;
                        cmd_code_d = byte_q;
                        if (takes_arg(byte_q)) state_d = ARG1;
                        else                   cmd_fire = 1'b1;
                    end
                    ARG1: begin
                        arg1_ld = 1'b1;
                        if (is_window(opcode_q)) begin
                            state_d = ARG2;
                        end else begin
                            cmd_fire = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    ARG2: begin
                        win_apply = 1'b1;
                        cmd_fire  = 1'b1;
                        state_d   = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        new_col_lo     = clamp_col(arg1_q);
        new_col_hi_raw = clamp_col(byte_q);
        new_col_hi     = (new_col_hi_raw < new_col_lo) ? new_col_lo : new_col_hi_raw;
        new_row_lo     = clamp_row(arg1_q);
        new_row_hi_raw = clamp_row(byte_q);
        new_row_hi     = (new_row_hi_raw < new_row_lo) ? new_row_lo : new_row_hi_raw;
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            opcode_q    <= 8'd0;
            arg1_q      <= 8'd0;
            cmd_q       <= 8'd0;
            cmd_valid_q <= 1'b0;
        end else begin
            cmd_valid_q <= cmd_fire;
            if (cmd_fire)  cmd_q    <= cmd_code_d;
            if (opcode_ld) opcode_q <= byte_q;
            if (arg1_ld)   arg1_q   <= byte_q;
        end
    end

    // window updates and pixel writes are mutually exclusive, both move the pointer
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            col_start    <= '0;
            col_end      <= COL_MAX[COL_W-1:0];
            row_start    <= '0;
            row_end      <= ROW_MAX[ROW_W-1:0];
            col_ptr      <= '0;
            row_ptr      <= '0;
            pix_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            pix_col_q    <= '0;
            pix_row_q    <= '0;
            pix_data_q   <= '0;
        end else begin
            pix_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            if (win_apply) begin
                if (opcode_q == 8'h15) begin
                    col_start <= new_col_lo;
                    col_end   <= new_col_hi;
                    col_ptr   <= new_col_lo;
                    row_ptr   <= row_start;
                end else begin
                    row_start <= new_row_lo;
                    row_end   <= new_row_hi;
                    row_ptr   <= new_row_lo;
                    col_ptr   <= col_start;
                end
            end else if (pix_fire) begin
                pix_we_q   <= 1'b1;
                pix_col_q  <= col_ptr;
                pix_row_q  <= row_ptr;
                pix_data_q <= N_COLOR_BITS'(byte_q);
                if (col_ptr == col_end) begin
                    col_ptr <= col_start;
                    if (row_ptr == row_end) begin
                        row_ptr      <= row_start;
                        frame_done_q <= 1'b1;
                    end else begin
                        row_ptr <= row_ptr + ROW_W'(1);
                    end
                end else begin
                    col_ptr <= col_ptr + COL_W'(1);
                end
            end
        end
    end

    assign link.o_BYTE       = byte_q;
    assign link.o_BYTE_DC    = byte_dc_q;
    assign link.o_BYTE_VALID = byte_valid_q;
    assign link.o_CMD        = cmd_q;
    assign link.o_CMD_VALID  = cmd_valid_q;
    assign link.o_PIX_WE     = pix_we_q;
    assign link.o_PIX_COL    = pix_col_q;
    assign link.o_PIX_ROW    = pix_row_q;
    assign link.o_PIX_DATA   = pix_data_q;
    assign link.o_FRAME_DONE = frame_done_q;
endmodule

// File: tb/tb_ssd1331_spi_receiver.sv
// tb/tb_ssd1331_spi_receiver.sv - directed self-checking bench for ssd1331_spi_receiver
module tb_ssd1331_spi_receiver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ssd1331_spi_receiver_if #(.COL_W(3), .ROW_W(3), .N_COLOR_BITS(8)) link();

    ssd1331_spi_receiver #(
        .NUM_COL(8), .NUM_ROW(8), .COL_W(3), .ROW_W(3), .N_COLOR_BITS(8)
    ) dut (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .link    (link.slave)
    );

    int checks = 0;
    int errors = 0;
    int lat;
    int orphan_fd = 0;
    logic [8:0]  byte_log[$];
    logic [7:0]  cmd_log[$];
    logic [14:0] pix_log[$];   // {frame_done, row, col, data}

    always @(negedge clk) begin
        if (link.o_BYTE_VALID) byte_log.push_back({link.o_BYTE_DC, link.o_BYTE});
        if (link.o_CMD_VALID)  cmd_log.push_back(link.o_CMD);
        if (link.o_PIX_WE)
            pix_log.push_back({link.o_FRAME_DONE, link.o_PIX_ROW, link.o_PIX_COL, link.o_PIX_DATA});
        if (link.o_FRAME_DONE && !link.o_PIX_WE) orphan_fd++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input logic dc, input int nbits, output int l);
        l = 0;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            link.i_SCK  = 1'b0;
            link.i_MOSI = b[i];
            link.i_DC   = dc;
            repeat (4) @(negedge clk);
            link.i_SCK = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (link.o_BYTE_VALID && l == 0) l = k;
            end
        end
        @(negedge clk);
        link.i_SCK = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic dc);
        int l;
        spi_bits(b, dc, 8, l);
    endtask

    task automatic clear_logs();
        byte_log.delete();
        cmd_log.delete();
        pix_log.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_a"}, {link.o_BYTE, link.o_BYTE_DC, link.o_BYTE_VALID, link.o_CMD, link.o_CMD_VALID}, 32'h0);
        check({tag, "_b"}, {link.o_PIX_WE, link.o_PIX_COL, link.o_PIX_ROW, link.o_PIX_DATA, link.o_FRAME_DONE}, 32'h0);
    endtask

    initial begin
        link.i_CS = 1'b1; link.i_SCK = 1'b0; link.i_MOSI = 1'b0; link.i_DC = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        link.i_CS = 1'b0;
        repeat (4) @(negedge clk);

        // display-on: SCK raised just after a negedge, captured on the next posedge,
        // valid 3 cycles after that and sampled on the 4th negedge
        spi_bits(8'hAF, 1'b0, 8, lat);
        check("af_latency", lat, 4);
        check("af_nbytes", byte_log.size(), 1);
        check("af_byte", byte_log[0], {1'b0, 8'hAF});
        check("af_ncmd", cmd_log.size(), 1);
        check("af_cmd", cmd_log[0], 8'hAF);
        check("af_npix", pix_log.size(), 0);
        clear_logs();

        // window col 2..5, row 1..3, then 12 pixels
        send(8'h15, 1'b0); send(8'h02, 1'b0); send(8'h05, 1'b0);
        send(8'h75, 1'b0); send(8'h01, 1'b0); send(8'h03, 1'b0);
        for (int k = 0; k < 12; k++) send(8'(k), 1'b1);
        check("win_nbytes", byte_log.size(), 18);
        check("win_ncmd", cmd_log.size(), 2);
        check("win_cmd0", cmd_log[0], 8'h15);
        check("win_cmd1", cmd_log[1], 8'h75);
        check("win_npix", pix_log.size(), 12);
        for (int k = 0; k < 12; k++)
            check("win_pix", pix_log[k], {(k == 11), 3'(1 + k / 4), 3'(2 + k % 4), 8'(k)});
        clear_logs();

        // full-frame wrap after reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 65; k++) send(8'(k), 1'b1);
        check("full_npix", pix_log.size(), 65);
        for (int k = 0; k < 64; k++)
            check("full_pix", pix_log[k], {(k == 63), 3'(k / 8), 3'(k % 8), 8'(k)});
        check("full_wrap", pix_log[64], {1'b0, 3'd0, 3'd0, 8'd64});
        check("full_ncmd", cmd_log.size(), 0);
        clear_logs();

        // clamped window: start 0x20 -> 7, end 1 raised to 7
        send(8'h15, 1'b0); send(8'h20, 1'b0); send(8'h01, 1'b0);
        send(8'h77, 1'b1); send(8'h78, 1'b1);
        check("clamp_ncmd", cmd_log.size(), 1);
        check("clamp_cmd", cmd_log[0], 8'h15);
        check("clamp_pix0", pix_log[0], {1'b0, 3'd0, 3'd7, 8'h77});
        check("clamp_pix1", pix_log[1], {1'b0, 3'd1, 3'd7, 8'h78});
        clear_logs();

        // partial byte discarded on CS raise
        spi_bits(8'hFF, 1'b0, 5, lat);
        link.i_CS = 1'b1;
        repeat (10) @(negedge clk);
        link.i_CS = 1'b0;
        repeat (4) @(negedge clk);
        send(8'hA5, 1'b0);
        check("part_nbytes", byte_log.size(), 1);
        check("part_byte", byte_log[0], {1'b0, 8'hA5});
        check("part_cmd", cmd_log[0], 8'hA5);
        clear_logs();

        // abandoned single-argument command, data byte goes to the pointer (7,2)
        send(8'h81, 1'b0); send(8'h3C, 1'b1);
        check("abandon_ncmd", cmd_log.size(), 0);
        check("abandon_npix", pix_log.size(), 1);
        check("abandon_pix", pix_log[0], {1'b0, 3'd2, 3'd7, 8'h3C});
        clear_logs();

        // reset mid-command
        send(8'h15, 1'b0); send(8'h02, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("midrst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h5A, 1'b1); send(8'h5B, 1'b1);
        check("midrst_ncmd", cmd_log.size(), 0);
        check("midrst_npix", pix_log.size(), 2);
        check("midrst_pix0", pix_log[0], {1'b0, 3'd0, 3'd0, 8'h5A});
        check("midrst_pix1", pix_log[1], {1'b0, 3'd0, 3'd1, 8'h5B});
        check("orphan_fd", orphan_fd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
